ram_march_tester: RTL and testbench
===================================

// Module: ram_march_tester
// PURPOSE
// - Initiator/checker that drives a 64x8 single-port synchronous RAM (registered read address,
//   read data valid one cycle after the address is presented) through a two-pass write/read-back test.
// - Sits beside the RAM in the memory subsystem; a controller pulses i_start and collects pass/fail status.
// PARAMETERS
// - ADDR_W  6      RAM address width; DEPTH = 2**ADDR_W
// - DATA_W  8      RAM data width
// - SEED    8'hA5  XOR seed for the data pattern (DATA_W bits)
// - ERR_W   8      width of the saturating error counter
// PORTS
// - i_clk              in   1       clock, rising edge
// - i_reset            in   1       asynchronous, active-high reset
// - i_start            in   1       start request; sampled only in IDLE
// - i_abort            in   1       abort the running test
// - o_ram_ce           out  1       RAM chip enable
// - o_ram_wr           out  1       RAM write enable
// - o_ram_addr         out  ADDR_W  RAM address
// - o_ram_wdata        out  DATA_W  RAM write data
// - i_ram_rdata        in   DATA_W  RAM read data
// - o_busy             out  1       test in progress
// - o_done             out  1       one-cycle pulse at normal completion
// - o_pass             out  1       last completed test had zero mismatches
// - o_err_cnt          out  ERR_W   mismatch count, saturating
// - o_fail_valid       out  1       first-failure record is valid
// - o_fail_addr        out  ADDR_W  address of the first mismatch
// - o_fail_pass        out  1       pass index (0/1) of the first mismatch
// - o_fail_data        out  DATA_W  data read at the first mismatch
// BEHAVIOUR
// - Reset: state=IDLE, all outputs 0. o_ram_ce=0 outside WRITE/READ.
// - All RAM-side outputs are decoded from registered state/counter only. There is no combinational input->output path.
// - Pattern: pat(a,p) = ({0,a} ^ SEED) when p=0; ~({0,a} ^ SEED) when p=1.
// - States: IDLE -> WRITE -> READ -> DRAIN -> (p==0 ? WRITE with p=1 : DONE) -> IDLE.
// - IDLE: i_start=1 at an edge clears err_cnt, pass, fail_*, p=0, addr=0 -> WRITE.
// - WRITE: ce=1, wr=1, addr=cnt, wdata=pat(cnt,p); runs DEPTH cycles (addr 0..DEPTH-1), then enters READ with cnt=0.
// - READ: ce=1, wr=0, addr=cnt; runs DEPTH cycles.
//   - A 1-cycle-delayed copy of (addr, valid) forms the expected-data pipe.
//   - In each cycle where the delayed valid is set, i_ram_rdata is compared with pat(delayed addr, p).
// - DRAIN: ce=0; 1 cycle; compares the last address (DEPTH-1).
// - Mismatch handling:
//   - err_cnt += 1, saturating at 2**ERR_W-1.
//   - If fail_valid==0: capture addr, p and rdata, then set fail_valid. Later mismatches never overwrite the record.
// - DONE: 1 cycle; o_done=1, o_pass=(err_cnt==0). Then IDLE. o_pass/err/fail_* hold until the next accepted start.
// - o_busy=1 in WRITE/READ/DRAIN/DONE.
// - Latency: start edge to o_done high = 2*(2*DEPTH+1)+1 cycles (259 for DEPTH=64). o_done is high in cycle 259 after the start edge.
// - Counter wrap: cnt reaches DEPTH-1, then the state changes. The address never exceeds DEPTH-1 and no extra access is issued.
// - i_start while busy: ignored, no restart.
// - i_start and i_abort together in IDLE: abort wins; stays IDLE.
// - i_abort while busy: IDLE at the next edge, ce=0, o_done not pulsed, o_pass=0. err_cnt/fail_* keep their partial values.
// - i_reset asserted mid-test: immediately IDLE, all outputs 0, no further RAM access.
// TESTING
// - Fault-free RAM model, pulse start -> busy for 258 cycles.
//   - Done pulse at cycle 259; pass=1, err_cnt=0, fail_valid=0.
//   - Writes at 0x00=8'hA5 (pass0) and 8'h5A (pass1).
// - RAM read bit0 stuck-at-0 -> err_cnt=64, pass=0.
//   - fail_addr=0, fail_pass=0, fail_data=8'hA4.
// - i_abort at cycle 100 -> IDLE next cycle, no done pulse, ce=0, pass=0.
// - i_start pulsed at cycles 10 and 150 of a run -> ignored; single done at 259.
// - i_reset asserted at cycle 70 (mid-READ) -> all outputs 0 asynchronously.
//   - After release, a new start runs a full clean test.
// - ERR_W=4 with stuck-bit RAM -> err_cnt saturates at 15; fail record still shows addr 0, pass 0.

Source files
------------

// File: rtl/ram_march_tester.sv
// Two-pass march tester for a synchronous single-port RAM.
// Writes an address-seeded pattern, reads it back and records the first failure.
module ram_march_tester #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED = 8'hA5,
  parameter int ERR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_ram_ce,
  output logic              o_ram_wr,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic              o_fail_valid,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic              o_fail_pass,
  output logic [DATA_W-1:0] o_fail_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic p_q, p_d;
  logic rv_q, rv_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic pass_q, pass_d;
  logic fv_q, fv_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic fp_q, fp_d;
  logic [DATA_W-1:0] fd_q, fd_d;
  logic go, kill, mism;

  function automatic logic [DATA_W-1:0] pat(
    input logic [ADDR_W-1:0] a,
    input logic p
  );
    logic [DATA_W-1:0] v;
    v = DATA_W'(a) ^ SEED;
    return p ? ~v : v;
  endfunction

  assign go = (state_q == S_IDLE) && i_start && !i_abort;
  // DONE is excluded so the verdict of a finished test is never lost
  assign kill = i_abort && (state_q != S_IDLE) && (state_q != S_DONE);
  assign mism = rv_q && !kill && (i_ram_rdata != pat(ra_q, p_q));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= 1'b0;
      rv_q    <= 1'b0;
      ra_q    <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fp_q    <= 1'b0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      rv_q    <= rv_d;
      ra_q    <= ra_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fp_q    <= fp_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_WRITE;
      S_WRITE: if (cnt_q == LAST) state_d = S_READ;
      S_READ:  if (cnt_q == LAST) state_d = S_DRAIN;
      S_DRAIN: state_d = p_q ? S_DONE : S_WRITE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d  = cnt_q;
    p_d    = p_q;
    rv_d   = (state_q == S_READ) && !kill;
    ra_d   = cnt_q;
    err_d  = err_q;
    pass_d = pass_q;
    fv_d   = fv_q;
    fa_d   = fa_q;
    fp_d   = fp_q;
    fd_d   = fd_q;
    if (mism) begin
      if (err_q != ERR_MAX) err_d = err_q + 1'b1;
      if (!fv_q) begin
        fv_d = 1'b1;
        fa_d = ra_q;
        fp_d = p_q;
        fd_d = i_ram_rdata;
      end
    end
    unique case (state_q)
      S_IDLE: if (go) begin
        cnt_d  = '0;
        p_d    = 1'b0;
        err_d  = '0;
        pass_d = 1'b0;
        fv_d   = 1'b0;
        fa_d   = '0;
        fp_d   = 1'b0;
        fd_d   = '0;
      end
      S_WRITE, S_READ: cnt_d = cnt_q + 1'b1;
      S_DRAIN: begin
        cnt_d = '0;
        p_d   = 1'b1;
      end
      S_DONE: pass_d = (err_q == '0);
      default: ;
    endcase
    if (kill) begin
      cnt_d  = '0;
      pass_d = 1'b0;
    end
  end

  always_comb begin
    o_ram_ce     = (state_q == S_WRITE) || (state_q == S_READ);
    o_ram_wr     = (state_q == S_WRITE);
    o_ram_addr   = o_ram_ce ? cnt_q : '0;
    o_ram_wdata  = o_ram_wr ? pat(cnt_q, p_q) : '0;
    o_busy       = (state_q != S_IDLE);
    o_done       = (state_q == S_DONE);
    o_pass       = o_done ? (err_q == '0) : pass_q;
    o_err_cnt    = err_q;
    o_fail_valid = fv_q;
    o_fail_addr  = fa_q;
    o_fail_pass  = fp_q;
    o_fail_data  = fd_q;
  end

endmodule

// File: tb/tb_ram_march_tester.sv
// Scoreboard bench for ram_march_tester with read-side stuck-at-0 fault masks.
// Two DUTs (ERR_W=8 and ERR_W=4) run the same stimulus against their own RAMs.
module tb_ram_march_tester;

  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [7:0] mask = 0;

  logic ce0, wr0, ce4, wr4;
  logic [5:0] a0, a4;
  logic [7:0] wd0, wd4, rd0, rd4;
  logic busy0, done0, pass0, fv0, fp0;
  logic busy4, done4, pass4, fv4, fp4;
  logic [7:0] err0, fd0, fd4;
  logic [3:0] err4;
  logic [5:0] fa0, fa4;
  logic [7:0] mem0 [64];
  logic [7:0] mem4 [64];

  int checks = 0, failures = 0;

  typedef struct {
    int err; bit fv; int fa; bit fp; int fd; bit pass;
  } res_t;
  res_t rq0[$];
  res_t rq4[$];
  logic [13:0] wq[$];

  always #5 clk = ~clk;

  ram_march_tester dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .o_ram_ce(ce0), .o_ram_wr(wr0), .o_ram_addr(a0), .o_ram_wdata(wd0),
    .i_ram_rdata(rd0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_cnt(err0), .o_fail_valid(fv0), .o_fail_addr(fa0),
    .o_fail_pass(fp0), .o_fail_data(fd0));

  ram_march_tester #(.ERR_W(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .o_ram_ce(ce4), .o_ram_wr(wr4), .o_ram_addr(a4), .o_ram_wdata(wd4),
    .i_ram_rdata(rd4), .o_busy(busy4), .o_done(done4), .o_pass(pass4),
    .o_err_cnt(err4), .o_fail_valid(fv4), .o_fail_addr(fa4),
    .o_fail_pass(fp4), .o_fail_data(fd4));

  always @(posedge clk) begin
    if (ce0) begin
      if (wr0) mem0[a0] <= wd0;
      else rd0 <= mem0[a0] & ~mask;
    end
    if (ce4) begin
      if (wr4) mem4[a4] <= wd4;
      else rd4 <= mem4[a4] & ~mask;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int a, input int p);
    logic [7:0] v;
    v = 8'(a) ^ 8'hA5;
    return (p != 0) ? ~v : v;
  endfunction

  function automatic res_t model(input logic [7:0] m);
    res_t r;
    logic [7:0] e, g;
    r = '{default: 0};
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 64; a++) begin
        e = pat(a, p);
        g = e & ~m;
        if (g != e) begin
          r.err++;
          if (!r.fv) begin
            r.fv = 1; r.fa = a; r.fp = p[0]; r.fd = g;
          end
        end
      end
    r.pass = (r.err == 0);
    return r;
  endfunction

  always @(negedge clk) begin
    res_t r;
    if (!rst && ce0 && wr0) begin
      if (wq.size() == 0) chk("unexpected_write", {18'd0, a0, wd0}, 0);
      else chk("ram_write", {18'd0, a0, wd0}, {18'd0, wq.pop_front()});
    end
    if (!rst && done0) begin
      if (rq0.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        r = rq0.pop_front();
        chk("pass", pass0, r.pass);
        chk("err_cnt", err0, r.err);
        chk("fail_valid", fv0, r.fv);
        chk("fail_addr", fa0, r.fa);
        chk("fail_pass", fp0, r.fp);
        chk("fail_data", fd0, r.fd);
      end
    end
    if (!rst && done4) begin
      if (rq4.size() == 0) chk("unexpected_done4", 1, 0);
      else begin
        r = rq4.pop_front();
        chk("pass4", pass4, r.pass);
        chk("err_cnt4", err4, (r.err > 15) ? 15 : r.err);
        chk("fail_valid4", fv4, r.fv);
        chk("fail_addr4", fa4, r.fa);
        chk("fail_pass4", fp4, r.fp);
      end
    end
  end

  task automatic zero_outs(input string nm);
    chk({nm, "_ce"}, ce0, 0);
    chk({nm, "_wr_addr_wd"}, {wr0, a0, wd0}, 0);
    chk({nm, "_busy_done"}, {busy0, done0}, 0);
    chk({nm, "_pass_err"}, {pass0, err0}, 0);
    chk({nm, "_fail"}, {fv0, fa0, fp0, fd0}, 0);
    chk({nm, "_dut4"}, {ce4, busy4, pass4, err4, fv4}, 0);
  endtask

  task automatic run(input logic [7:0] m, input int abort_at,
                     input int reset_at, input bit extra);
    res_t r;
    int n, bad;
    bit full, fin;
    full = (abort_at == 0) && (reset_at == 0);
    mask = m;
    r = model(m);
    for (int p = 0; p < (full ? 2 : 1); p++)
      for (int a = 0; a < 64; a++) wq.push_back({6'(a), pat(a, p)});
    if (full) begin
      rq0.push_back(r);
      rq4.push_back(r);
    end
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    n = 0; bad = 0; fin = 0;
    while (!fin && n < 300) begin
      @(negedge clk);
      n++;
      start = extra && (n == 10 || n == 150);
      if (abort_at != 0 && n == abort_at) abort = 1;
      if (abort_at != 0 && n == abort_at + 1) begin
        abort = 0;
        chk("abort_idle", {busy0, ce0, done0, pass0}, 0);
        fin = 1;
      end
      if (reset_at != 0 && n == reset_at) begin
        rst = 1;
        #1 zero_outs("reset_mid");
        @(posedge clk); #1 chk("reset_no_ce", {ce0, ce4}, 0);
        rst = 0;
        fin = 1;
      end
      if (full && n < 259 && (!busy0 || done0)) bad++;
      if (full && done0) begin
        chk("done_cycle", n, 259);
        chk("busy_at_done", busy0, 1);
        chk("busy_before_done", bad, 0);
        fin = 1;
      end
    end
    if (!fin) chk("timeout", n, 0);
    start = 0;
    repeat (6) @(negedge clk);
    if (full) chk("pass_hold", pass0, r.pass);
    chk("write_queue_empty", wq.size(), 0);
    chk("result_queue_empty", rq0.size() + rq4.size(), 0);
    wq.delete(); rq0.delete(); rq4.delete();
  endtask

  initial begin
    #1 zero_outs("reset");
    #20 rst = 0;
    run(8'h00, 0, 0, 0);
    run(8'h01, 0, 0, 0);
    for (int i = 0; i < 3; i++) run(8'($urandom_range(1, 255)), 0, 0, 0);
    run(8'h00, 0, 0, 1);
    run(8'h00, 100, 0, 0);
    @(negedge clk); start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    chk("start_abort_idle", {busy0, ce0}, 0);
    run(8'h00, 0, 70, 0);
    run(8'h00, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
